// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the ID/EX stage.
// It picks a per-operand forward source from EX/MEM or MEM/WB and holds
// the pipeline for LOAD_LAT cycles on a load-use hazard. Flush aborts a
// hold in progress. Two saturating performance counters track stall and
// forwarding cycles.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid_i,
  input  logic [6:0]        id_opcode_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [6:0]        ex_mem_opcode_i,
  input  logic [6:0]        mem_wb_opcode_i,
  input  logic [1:0]        ex_mem_wb_sel_i,
  input  logic [1:0]        mem_wb_wb_sel_i,
  input  logic [REG_AW-1:0] ex_mem_dest_i,
  input  logic [REG_AW-1:0] mem_wb_dest_i,
  input  logic              flush_i,
  input  logic              perf_clr_i,
  output logic [1:0]        fa_mux_o,
  output logic [1:0]        fb_mux_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [1:0] NO_WRITEBACK     = 2'd0;
  localparam logic [1:0] ORIGINAL_SELECT  = 2'd0;
  localparam logic [1:0] EX_RESULT_SELECT = 2'd1;
  localparam logic [1:0] WB_RESULT_SELECT = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(LOAD_LAT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;

  logic use_a, use_b, ex_wr, wb_wr;
  logic ex_a, ex_b, wb_a, wb_b, lu_a, lu_b, stall_raw;

  // Source usage per opcode class and per-operand match against each stage.
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    if (id_valid_i) begin
      case (id_opcode_i)
        OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
          use_a = 1'b1;
          use_b = 1'b1;
        end
        OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: use_a = 1'b1;
        default: ;
      endcase
    end
    ex_wr = (ex_mem_wb_sel_i != NO_WRITEBACK) && (ex_mem_dest_i != '0);
    wb_wr = (mem_wb_wb_sel_i != NO_WRITEBACK) && (mem_wb_dest_i != '0);
    ex_a  = use_a && ex_wr && (ex_mem_dest_i == id_rs1_i);
    ex_b  = use_b && ex_wr && (ex_mem_dest_i == id_rs2_i);
    wb_a  = use_a && wb_wr && (mem_wb_dest_i == id_rs1_i);
    wb_b  = use_b && wb_wr && (mem_wb_dest_i == id_rs2_i);
    lu_a  = ex_a && (ex_mem_opcode_i == OPCODE_LOAD);
    lu_b  = ex_b && (ex_mem_opcode_i == OPCODE_LOAD);
  end

  // Independent forward selects; a load-use operand stays on the original path.
  always_comb begin
    fa_mux_o = ORIGINAL_SELECT;
    fb_mux_o = ORIGINAL_SELECT;
    if (!reset) begin
      if (lu_a)      fa_mux_o = ORIGINAL_SELECT;
      else if (ex_a) fa_mux_o = EX_RESULT_SELECT;
      else if (wb_a) fa_mux_o = WB_RESULT_SELECT;
      if (lu_b)      fb_mux_o = ORIGINAL_SELECT;
      else if (ex_b) fb_mux_o = EX_RESULT_SELECT;
      else if (wb_b) fb_mux_o = WB_RESULT_SELECT;
    end
  end

  // Stall FSM next state; hazard detection is ignored while in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_raw = (lu_a || lu_b) && !flush_i;
        if (stall_raw && (LOAD_LAT > 1)) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        stall_raw = !flush_i;
        cnt_d     = cnt_q - 4'd1;
        if ((cnt_q == 4'd1) || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_o     = stall_raw && !reset;
  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;

  // FSM state and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!stall_o && ((fa_mux_o != ORIGINAL_SELECT) || (fb_mux_o != ORIGINAL_SELECT))
          && (fwd_cnt_q != '1))
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a combinational vector table plus
// hand-written multi-cycle sequences on two configurations.
module tb_fwd_hazard_ctrl;

  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LD = 7'h03, ST = 7'h23;
  localparam logic [6:0] BR = 7'h63, JALR = 7'h67, LUI = 7'h37;
  localparam logic [1:0] NOWB = 2'd0, ALU = 2'd1, MEM = 2'd2;
  localparam logic [1:0] ORIG = 2'd0, EXS = 2'd1, WBS = 2'd2;

  logic clk = 1'b0, reset = 1'b1;
  logic id_valid_i, flush_i, perf_clr_i;
  logic [6:0] id_opcode_i, ex_mem_opcode_i, mem_wb_opcode_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_mem_dest_i, mem_wb_dest_i;
  logic [1:0] ex_mem_wb_sel_i, mem_wb_wb_sel_i;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic st0, st1;
  logic [31:0] sc0, fc0;
  logic [2:0]  sc1, fc1;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_mem_opcode_i(ex_mem_opcode_i),
    .mem_wb_opcode_i(mem_wb_opcode_i), .ex_mem_wb_sel_i(ex_mem_wb_sel_i),
    .mem_wb_wb_sel_i(mem_wb_wb_sel_i), .ex_mem_dest_i(ex_mem_dest_i),
    .mem_wb_dest_i(mem_wb_dest_i), .flush_i(flush_i), .perf_clr_i(perf_clr_i),
    .fa_mux_o(fa0), .fb_mux_o(fb0), .stall_o(st0), .stall_cnt_o(sc0), .fwd_cnt_o(fc0));

  fwd_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_mem_opcode_i(ex_mem_opcode_i),
    .mem_wb_opcode_i(mem_wb_opcode_i), .ex_mem_wb_sel_i(ex_mem_wb_sel_i),
    .mem_wb_wb_sel_i(mem_wb_wb_sel_i), .ex_mem_dest_i(ex_mem_dest_i),
    .mem_wb_dest_i(mem_wb_dest_i), .flush_i(flush_i), .perf_clr_i(perf_clr_i),
    .fa_mux_o(fa1), .fb_mux_o(fb1), .stall_o(st1), .stall_cnt_o(sc1), .fwd_cnt_o(fc1));

  typedef struct {
    logic       valid;
    logic [6:0] opc;
    logic [4:0] rs1, rs2;
    logic [6:0] exop;
    logic [1:0] exsel;
    logic [4:0] exdst;
    logic [6:0] wbop;
    logic [1:0] wbsel;
    logic [4:0] wbdst;
    logic [1:0] efa, efb;
    logic       estall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] exop, input logic [1:0] exsel, input logic [4:0] exdst,
                       input logic [6:0] wbop, input logic [1:0] wbsel, input logic [4:0] wbdst);
    id_valid_i = v;  id_opcode_i = opc; id_rs1_i = r1; id_rs2_i = r2;
    ex_mem_opcode_i = exop; ex_mem_wb_sel_i = exsel; ex_mem_dest_i = exdst;
    mem_wb_opcode_i = wbop; mem_wb_wb_sel_i = wbsel; mem_wb_dest_i = wbdst;
  endtask

  // Consumer BRANCH rs1=x1 rs2=x7 with a LOAD x7 in EX/MEM.
  task automatic hazard();
    drive(1'b1, BR, 5'd1, 5'd7, LD, MEM, 5'd7, 7'h00, NOWB, 5'd0);
  endtask

  // Stalled pipeline: bubble in EX/MEM, load held in MEM/WB.
  task automatic bubble();
    drive(1'b1, BR, 5'd1, 5'd7, 7'h00, NOWB, 5'd0, LD, MEM, 5'd7);
  endtask

  task automatic idle_in();
    drive(1'b0, 7'h00, 5'd0, 5'd0, 7'h00, NOWB, 5'd0, 7'h00, NOWB, 5'd0);
  endtask

  task automatic do_reset();
    idle_in();
    flush_i = 1'b0; perf_clr_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, OP,    5'd1,  5'd2,  OP, ALU,  5'd1, OP, ALU, 5'd2, EXS,  WBS,  1'b0};
    vecs[1]  = '{1'b1, OPIMM, 5'd5,  5'd5,  OP, ALU,  5'd5, OP, ALU, 5'd5, EXS,  ORIG, 1'b0};
    vecs[2]  = '{1'b1, OPIMM, 5'd0,  5'd0,  OP, ALU,  5'd0, OP, ALU, 5'd0, ORIG, ORIG, 1'b0};
    vecs[3]  = '{1'b1, OP,    5'd4,  5'd4,  OP, NOWB, 5'd4, OP, ALU, 5'd4, WBS,  WBS,  1'b0};
    vecs[4]  = '{1'b1, LUI,   5'd1,  5'd2,  OP, ALU,  5'd1, OP, ALU, 5'd2, ORIG, ORIG, 1'b0};
    vecs[5]  = '{1'b0, OP,    5'd1,  5'd2,  OP, ALU,  5'd1, OP, ALU, 5'd2, ORIG, ORIG, 1'b0};
    vecs[6]  = '{1'b1, ST,    5'd3,  5'd6,  OP, ALU,  5'd6, LD, MEM, 5'd3, WBS,  EXS,  1'b0};
    vecs[7]  = '{1'b1, JALR,  5'd9,  5'd9,  OP, ALU,  5'd8, OP, ALU, 5'd9, WBS,  ORIG, 1'b0};
    vecs[8]  = '{1'b1, BR,    5'd10, 5'd11, OP, ALU,  5'd8, OP, ALU, 5'd9, ORIG, ORIG, 1'b0};
    vecs[9]  = '{1'b1, LUI,   5'd1,  5'd1,  LD, MEM,  5'd1, OP, NOWB, 5'd0, ORIG, ORIG, 1'b0};
    vecs[10] = '{1'b1, OP,    5'd0,  5'd3,  LD, MEM,  5'd0, OP, NOWB, 5'd0, ORIG, ORIG, 1'b0};
    vecs[11] = '{1'b1, OP,    5'd1,  5'd3,  LD, NOWB, 5'd1, OP, NOWB, 5'd0, ORIG, ORIG, 1'b0};

    idle_in();
    flush_i = 1'b0; perf_clr_i = 1'b0;
    #2;
    chk("reset_stall", {31'd0, st0}, 32'd0);
    chk("reset_fa", {30'd0, fa0}, {30'd0, ORIG});
    do_reset();
    chk("reset_stall_cnt", sc0, 32'd0);
    chk("reset_fwd_cnt", fc0, 32'd0);

    // Table: combinational selects, one vector per cycle.
    for (int unsigned i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].opc, vecs[i].rs1, vecs[i].rs2, vecs[i].exop, vecs[i].exsel,
            vecs[i].exdst, vecs[i].wbop, vecs[i].wbsel, vecs[i].wbdst);
      #1;
      chk($sformatf("vec%0d_fa", i), {30'd0, fa0}, {30'd0, vecs[i].efa});
      chk($sformatf("vec%0d_fb", i), {30'd0, fb0}, {30'd0, vecs[i].efb});
      chk($sformatf("vec%0d_stall", i), {31'd0, st0}, {31'd0, vecs[i].estall});
      tick();
    end
    chk("table_fwd_cnt", fc0, 32'd5);
    chk("table_stall_cnt", sc0, 32'd0);

    // LOAD_LAT=3: exactly three stall cycles, then WB forward on release.
    do_reset();
    hazard(); #1;
    chk("lu3_stall_c1", {31'd0, st0}, 32'd1);
    chk("lu3_fb_hazard", {30'd0, fb0}, {30'd0, ORIG});
    tick();
    for (int unsigned c = 2; c <= 3; c++) begin
      bubble(); #1;
      chk($sformatf("lu3_stall_c%0d", c), {31'd0, st0}, 32'd1);
      tick();
    end
    bubble(); #1;
    chk("lu3_release_stall", {31'd0, st0}, 32'd0);
    chk("lu3_release_fb", {30'd0, fb0}, {30'd0, WBS});
    chk("lu3_stall_cnt", sc0, 32'd3);
    tick();
    chk("lu3_fwd_cnt", fc0, 32'd1);
    drive(1'b1, OP, 5'd2, 5'd3, 7'h00, NOWB, 5'd0, 7'h00, NOWB, 5'd0); #1;
    chk("lu3_no_retrigger", {31'd0, st0}, 32'd0);
    tick();
    // Both operands hazarded by the same load: still one 3-cycle stall.
    drive(1'b1, OP, 5'd7, 5'd7, LD, MEM, 5'd7, 7'h00, NOWB, 5'd0); #1;
    chk("both_stall_c1", {31'd0, st0}, 32'd1);
    tick();
    for (int unsigned c = 2; c <= 4; c++) begin
      drive(1'b1, OP, 5'd7, 5'd7, 7'h00, NOWB, 5'd0, LD, MEM, 5'd7); #1;
      chk($sformatf("both_stall_c%0d", c), {31'd0, st0}, (c <= 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("both_stall_cnt", sc0, 32'd6);

    // LOAD_LAT=4 with flush in the second stall cycle.
    do_reset();
    hazard(); #1;
    chk("fl_stall_c1", {31'd0, st1}, 32'd1);
    tick();
    bubble(); flush_i = 1'b1; #1;
    chk("fl_stall_flushed", {31'd0, st1}, 32'd0);
    tick();
    flush_i = 1'b0; bubble(); #1;
    chk("fl_idle_after", {31'd0, st1}, 32'd0);
    chk("fl_stall_cnt", {29'd0, sc1}, 32'd1);
    tick();
    // Flush in IDLE suppresses a new stall.
    hazard(); flush_i = 1'b1; #1;
    chk("fl_idle_suppress", {31'd0, st1}, 32'd0);
    tick();
    flush_i = 1'b0;

    // Reset pulsed mid-WAIT.
    do_reset();
    hazard(); tick();
    bubble(); #1;
    chk("rst_wait_stall", {31'd0, st1}, 32'd1);
    reset = 1'b1; #1;
    chk("rst_stall_drop", {31'd0, st1}, 32'd0);
    chk("rst_stall_cnt", {29'd0, sc1}, 32'd0);
    chk("rst_fb_orig", {30'd0, fb1}, {30'd0, ORIG});
    tick();
    reset = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      bubble(); #1;
      chk($sformatf("rst_after_c%0d", c), {31'd0, st1}, 32'd0);
      tick();
    end
    hazard(); #1;
    chk("rst_new_hazard", {31'd0, st1}, 32'd1);
    tick();

    // Saturation on the 3-bit counter instance.
    do_reset();
    hazard(); tick();
    for (int unsigned c = 0; c < 4; c++) begin bubble(); tick(); end
    chk("sat_first_run", {29'd0, sc1}, 32'd4);
    hazard(); tick();
    bubble(); tick();
    bubble(); flush_i = 1'b1; tick();
    flush_i = 1'b0;
    chk("sat_preload", {29'd0, sc1}, 32'd6);
    idle_in(); tick();
    hazard(); tick();
    bubble(); tick();
    bubble(); tick();
    chk("sat_at_max", {29'd0, sc1}, 32'd7);
    bubble(); tick();
    chk("sat_hold", {29'd0, sc1}, 32'd7);
    bubble(); perf_clr_i = 1'b1; tick();
    perf_clr_i = 1'b0;
    chk("clr_stall_cnt", {29'd0, sc1}, 32'd0);
    chk("clr_fwd_cnt", {29'd0, fc1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
